// File: rtl/dphy_pkg.sv
// Shared D-PHY definitions: sequencer state codes, LP line codes and default
// timing/sync constants used by the data- and clock-lane sequencers.
package dphy_pkg;

  localparam int unsigned TIMER_BITS = 8;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hB8;

  // Lane sequencer states; plain constants keep the encoding explicit for tools.
  typedef logic [2:0] dphy_state_t;
  localparam dphy_state_t ST_IDLE    = 3'd0;
  localparam dphy_state_t ST_LP01    = 3'd1;
  localparam dphy_state_t ST_LP00    = 3'd2;
  localparam dphy_state_t ST_HS_ZERO = 3'd3;
  localparam dphy_state_t ST_SYNC    = 3'd4;
  localparam dphy_state_t ST_DATA    = 3'd5;
  localparam dphy_state_t ST_TRAIL   = 3'd6;
  localparam dphy_state_t ST_EXIT    = 3'd7;

  // LP line codes as {lp_p, lp_n}.
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

endpackage

// File: rtl/dphy_interval_timer.sv
// Down-counter for D-PHY state intervals: loads max(value,1)-1 and reports
// expiry at zero, so any programmed count of 0 or 1 lasts a single cycle.
module dphy_interval_timer #(
  parameter int unsigned g_timer_bits = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic [g_timer_bits-1:0] i_value,
  output logic                    o_expired
);

  logic [g_timer_bits-1:0] r_count;
  logic [g_timer_bits-1:0] w_reload;

  assign w_reload  = (i_value == '0) ? '0 : (i_value - 1'b1);
  assign o_expired = (r_count == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= w_reload;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/dphy_lane_sequencer.sv
// Per-lane D-PHY sequencer: LP-11 -> LP-01 -> LP-00 -> HS-0 -> sync -> payload
// -> trail -> LP-11, with all lane outputs registered from the next state.
module dphy_lane_sequencer
  import dphy_pkg::*;
#(
  parameter int unsigned g_timer_bits = TIMER_BITS,
  parameter logic [7:0]  g_sync_byte  = SYNC_BYTE_DEFAULT
) (
  input  logic                    clk_dsi_i,
  input  logic                    rst_n_a_i,
  input  logic                    enable_i,
  input  logic                    req_i,
  input  logic [g_timer_bits-1:0] tlpx_i,
  input  logic [g_timer_bits-1:0] ths_prepare_i,
  input  logic [g_timer_bits-1:0] ths_zero_i,
  input  logic [g_timer_bits-1:0] ths_trail_i,
  input  logic [g_timer_bits-1:0] ths_exit_i,
  input  logic [7:0]              d_i,
  input  logic                    valid_i,
  input  logic                    last_i,
  output logic                    ready_o,
  output logic [7:0]              serdes_data_o,
  output logic                    serdes_oe_o,
  output logic                    lp_p_o,
  output logic                    lp_n_o,
  output logic                    lp_oe_o,
  output logic                    busy_o,
  output logic                    underrun_o
);

  dphy_state_t             r_state;
  dphy_state_t             w_state_d;

  logic [g_timer_bits-1:0] r_sh_prepare;
  logic [g_timer_bits-1:0] r_sh_zero;
  logic [g_timer_bits-1:0] r_sh_trail;
  logic [g_timer_bits-1:0] r_sh_exit;

  logic                    r_last_bit;
  logic                    w_last_bit_d;

  logic                    r_ready;
  logic                    w_ready_d;
  logic [7:0]              r_data;
  logic [7:0]              w_data_d;
  logic                    r_serdes_oe;
  logic                    w_serdes_oe_d;
  logic                    r_lp_p;
  logic                    w_lp_p_d;
  logic                    r_lp_n;
  logic                    w_lp_n_d;
  logic                    r_lp_oe;
  logic                    w_lp_oe_d;
  logic                    r_busy;
  logic                    r_underrun;
  logic                    w_underrun_d;

  logic                    w_timer_load;
  logic [g_timer_bits-1:0] w_timer_value;
  logic                    w_timer_expired;
  logic                    w_sample_timing;
  logic                    w_start;

  assign w_start = req_i & enable_i;

  // Next-state logic; SYNC and DATA share the handshake since ready is already
  // high during the sync word so the first byte follows it without a gap.
  always_comb begin
    w_state_d    = r_state;
    w_ready_d    = 1'b0;
    w_underrun_d = 1'b0;
    w_last_bit_d = r_last_bit;
    case (r_state)
      ST_IDLE:    if (w_start) w_state_d = ST_LP01;
      ST_LP01:    if (w_timer_expired) w_state_d = ST_LP00;
      ST_LP00:    if (w_timer_expired) w_state_d = ST_HS_ZERO;
      ST_HS_ZERO: if (w_timer_expired) w_state_d = ST_SYNC;
      ST_SYNC, ST_DATA: begin
        if (r_ready) begin
          if (valid_i) begin
            w_state_d    = ST_DATA;
            w_ready_d    = ~last_i;
            w_last_bit_d = d_i[7];
          end else begin
            w_state_d    = ST_TRAIL;
            w_underrun_d = 1'b1;
          end
        end else begin
          w_state_d = ST_TRAIL;
        end
      end
      ST_TRAIL:   if (w_timer_expired) w_state_d = ST_EXIT;
      ST_EXIT: begin
        if (w_timer_expired) begin
          w_state_d = w_start ? ST_LP01 : ST_IDLE;
        end
      end
      default:    w_state_d = ST_IDLE;
    endcase

    if ((w_state_d == ST_SYNC) && (r_state != ST_SYNC)) begin
      w_ready_d    = 1'b1;
      w_last_bit_d = g_sync_byte[7];
    end
  end

  // Timer reloads on every state change with the interval of the new state.
  assign w_timer_load    = (w_state_d != r_state);
  assign w_sample_timing = (w_state_d == ST_LP01) && (r_state != ST_LP01);

  always_comb begin
    case (w_state_d)
      ST_LP01:    w_timer_value = tlpx_i;
      ST_LP00:    w_timer_value = r_sh_prepare;
      ST_HS_ZERO: w_timer_value = r_sh_zero;
      ST_TRAIL:   w_timer_value = r_sh_trail;
      ST_EXIT:    w_timer_value = r_sh_exit;
      default:    w_timer_value = '0;
    endcase
  end

  dphy_interval_timer #(
    .g_timer_bits (g_timer_bits)
  ) u_timer (
    .i_clk     (clk_dsi_i),
    .i_rst_n   (rst_n_a_i),
    .i_load    (w_timer_load),
    .i_value   (w_timer_value),
    .o_expired (w_timer_expired)
  );

  // Output decode of the next state so every pin is a flop.
  always_comb begin
    {w_lp_p_d, w_lp_n_d} = LP11;
    w_lp_oe_d            = 1'b1;
    w_serdes_oe_d        = 1'b0;
    w_data_d             = 8'h00;
    case (w_state_d)
      ST_IDLE:    w_lp_oe_d = enable_i;
      ST_LP01:    {w_lp_p_d, w_lp_n_d} = LP01;
      ST_LP00:    {w_lp_p_d, w_lp_n_d} = LP00;
      ST_HS_ZERO: begin
        {w_lp_p_d, w_lp_n_d} = LP00;
        w_lp_oe_d            = 1'b0;
        w_serdes_oe_d        = 1'b1;
      end
      ST_SYNC: begin
        {w_lp_p_d, w_lp_n_d} = LP00;
        w_lp_oe_d            = 1'b0;
        w_serdes_oe_d        = 1'b1;
        w_data_d             = g_sync_byte;
      end
      ST_DATA: begin
        {w_lp_p_d, w_lp_n_d} = LP00;
        w_lp_oe_d            = 1'b0;
        w_serdes_oe_d        = 1'b1;
        w_data_d             = d_i;
      end
      ST_TRAIL: begin
        // Trail drives the inverse of the final transmitted bit.
        {w_lp_p_d, w_lp_n_d} = LP00;
        w_lp_oe_d            = 1'b0;
        w_serdes_oe_d        = 1'b1;
        w_data_d             = r_last_bit ? 8'h00 : 8'hFF;
      end
      default: begin
        {w_lp_p_d, w_lp_n_d} = LP11;
      end
    endcase
  end

  always_ff @(posedge clk_dsi_i or negedge rst_n_a_i) begin
    if (!rst_n_a_i) begin
      r_state      <= ST_IDLE;
      r_sh_prepare <= '0;
      r_sh_zero    <= '0;
      r_sh_trail   <= '0;
      r_sh_exit    <= '0;
      r_last_bit   <= 1'b0;
      r_ready      <= 1'b0;
      r_data       <= 8'h00;
      r_serdes_oe  <= 1'b0;
      r_lp_p       <= 1'b1;
      r_lp_n       <= 1'b1;
      r_lp_oe      <= 1'b0;
      r_busy       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      if (w_sample_timing) begin
        r_sh_prepare <= ths_prepare_i;
        r_sh_zero    <= ths_zero_i;
        r_sh_trail   <= ths_trail_i;
        r_sh_exit    <= ths_exit_i;
      end
      r_last_bit   <= w_last_bit_d;
      r_ready      <= w_ready_d;
      r_data       <= w_data_d;
      r_serdes_oe  <= w_serdes_oe_d;
      r_lp_p       <= w_lp_p_d;
      r_lp_n       <= w_lp_n_d;
      r_lp_oe      <= w_lp_oe_d;
      r_busy       <= (w_state_d != ST_IDLE);
      r_underrun   <= w_underrun_d;
    end
  end

  assign ready_o       = r_ready;
  assign serdes_data_o = r_data;
  assign serdes_oe_o   = r_serdes_oe;
  assign lp_p_o        = r_lp_p;
  assign lp_n_o        = r_lp_n;
  assign lp_oe_o       = r_lp_oe;
  assign busy_o        = r_busy;
  assign underrun_o    = r_underrun;

endmodule

// File: tb/tb_dphy_lane_sequencer.sv
// Scoreboard bench for dphy_lane_sequencer: each burst pushes its expected
// per-cycle lane trace; a negedge monitor pops and compares while busy.
module tb_dphy_lane_sequencer;

  typedef struct packed {
    logic       lp_p;
    logic       lp_n;
    logic       lp_oe;
    logic       soe;
    logic       ready;
    logic       busy;
    logic       und;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_i;
  logic       req_i;
  logic [7:0] tlpx_i, ths_prepare_i, ths_zero_i, ths_trail_i, ths_exit_i;
  logic [7:0] d_i;
  logic       valid_i;
  logic       last_i;
  logic       ready_o;
  logic [7:0] serdes_data_o;
  logic       serdes_oe_o;
  logic       lp_p_o, lp_n_o, lp_oe_o;
  logic       busy_o;
  logic       underrun_o;

  int   n_total = 0;
  int   n_bad   = 0;
  int   mon_idx = 0;
  bit   check_en = 1'b1;
  bit   armed    = 1'b0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [14:0] mon_act, mon_exp;

  always #5 clk = ~clk;

  dphy_lane_sequencer #(
    .g_timer_bits (8),
    .g_sync_byte  (8'hB8)
  ) dut (
    .clk_dsi_i     (clk),
    .rst_n_a_i     (rst_n),
    .enable_i      (enable_i),
    .req_i         (req_i),
    .tlpx_i        (tlpx_i),
    .ths_prepare_i (ths_prepare_i),
    .ths_zero_i    (ths_zero_i),
    .ths_trail_i   (ths_trail_i),
    .ths_exit_i    (ths_exit_i),
    .d_i           (d_i),
    .valid_i       (valid_i),
    .last_i        (last_i),
    .ready_o       (ready_o),
    .serdes_data_o (serdes_data_o),
    .serdes_oe_o   (serdes_oe_o),
    .lp_p_o        (lp_p_o),
    .lp_n_o        (lp_n_o),
    .lp_oe_o       (lp_oe_o),
    .busy_o        (busy_o),
    .underrun_o    (underrun_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mx1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic push_n(input logic p, input logic n, input logic oe, input logic soe,
                        input logic rdy, input logic und, input logic [7:0] data,
                        input int cnt);
    exp_t e;
    e.lp_p = p; e.lp_n = n; e.lp_oe = oe; e.soe = soe;
    e.ready = rdy; e.busy = 1'b1; e.und = und; e.data = data;
    for (int i = 0; i < cnt; i++) sb_q.push_back(e);
  endtask

  // Expected lane trace of one burst, derived from the programmed timings.
  task automatic push_burst(input int tl, input int pr, input int ze, input int tr,
                            input int ex, input logic [7:0] b[$], input int n,
                            input bit und);
    logic [7:0] sync_b;
    logic [7:0] tw;
    logic       lb;
    sync_b = 8'hB8;
    push_n(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, mx1(tl));
    push_n(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, mx1(pr));
    push_n(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, mx1(ze));
    push_n(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, sync_b, 1);
    lb = sync_b[7];
    for (int k = 0; k < n; k++) begin
      push_n(1'b0, 1'b0, 1'b0, 1'b1, (und || (k != n - 1)), 1'b0, b[k], 1);
      lb = b[k][7];
    end
    tw = lb ? 8'h00 : 8'hFF;
    push_n(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, und, tw, 1);
    push_n(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, tw, mx1(tr) - 1);
    push_n(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, mx1(ex));
  endtask

  task automatic set_timing(input int tl, input int pr, input int ze, input int tr,
                            input int ex);
    tlpx_i = 8'(tl); ths_prepare_i = 8'(pr); ths_zero_i = 8'(ze);
    ths_trail_i = 8'(tr); ths_exit_i = 8'(ex);
  endtask

  task automatic start_req(input bit hold);
    @(negedge clk);
    req_i = 1'b1;
    @(posedge clk);
    #1;
    armed = 1'b1;
    if (!hold) req_i = 1'b0;
  endtask

  // Feeds n bytes through the valid/ready handshake; und drops valid after them.
  task automatic drive_bytes(input logic [7:0] b[$], input int n, input bit und);
    int  idx = 0;
    int  budget = 0;
    bit  hs;
    if (n == 0) begin
      valid_i = 1'b0;
      return;
    end
    valid_i = 1'b1; d_i = b[0]; last_i = !und && (n == 1);
    while (idx < n && budget < 300) begin
      @(negedge clk);
      hs = ready_o && valid_i;
      @(posedge clk);
      #1;
      budget++;
      if (hs) begin
        idx++;
        if (idx < n) begin
          d_i = b[idx]; last_i = !und && (idx == n - 1);
        end else begin
          valid_i = 1'b0; last_i = 1'b0;
        end
      end
    end
    if (idx < n) chk("handshake_budget", idx, n);
    valid_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (sb_q.size() != 0 && budget < 400) begin
      @(negedge clk);
      #1;
      budget++;
    end
    chk("trace_drained", sb_q.size(), 0);
    sb_q.delete();
    armed = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_lp"}, {lp_oe_o, lp_p_o, lp_n_o}, 3'b111);
    chk({tag, "_soe"}, serdes_oe_o, 0);
  endtask

  always @(negedge clk) begin
    if (check_en && rst_n) begin
      if (armed && sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        mon_act = {lp_oe_o, serdes_oe_o, ready_o, busy_o, underrun_o,
                   mon_e.lp_oe ? {lp_p_o, lp_n_o} : 2'b00,
                   mon_e.soe ? serdes_data_o : 8'h00};
        mon_exp = {mon_e.lp_oe, mon_e.soe, mon_e.ready, mon_e.busy, mon_e.und,
                   mon_e.lp_oe ? {mon_e.lp_p, mon_e.lp_n} : 2'b00,
                   mon_e.soe ? mon_e.data : 8'h00};
        chk($sformatf("cycle%0d", mon_idx), {17'b0, mon_act}, {17'b0, mon_exp});
        mon_idx++;
      end else if (busy_o) begin
        chk("unexpected_busy", busy_o, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bq[$];
    logic [7:0] b2[$];
    int         l1, l2, bb;

    rst_n = 1'b0; enable_i = 1'b1; req_i = 1'b0;
    valid_i = 1'b0; d_i = 8'h00; last_i = 1'b0;
    set_timing(2, 2, 2, 2, 2);

    // Reset state
    @(negedge clk);
    chk("rst_lp_oe", lp_oe_o, 0);
    chk("rst_lp_pins", {lp_p_o, lp_n_o}, 2'b11);
    chk("rst_soe", serdes_oe_o, 0);
    chk("rst_data", serdes_data_o, 8'h00);
    chk("rst_ready_busy_und", {ready_o, busy_o, underrun_o}, 3'b000);
    rst_n = 1'b1;
    idle_chk("post_rst");

    // Nominal burst
    set_timing(2, 3, 4, 5, 6);
    bq = '{8'h11, 8'h22, 8'h83};
    push_burst(2, 3, 4, 5, 6, bq, 3, 1'b0);
    start_req(1'b0);
    drive_bytes(bq, 3, 1'b0);
    drain();
    idle_chk("after_a");

    // All timings zero, last byte 0x7F
    set_timing(0, 0, 0, 0, 0);
    bq = '{8'h05, 8'h7F};
    push_burst(0, 0, 0, 0, 0, bq, 2, 1'b0);
    start_req(1'b0);
    drive_bytes(bq, 2, 1'b0);
    drain();
    idle_chk("after_zero");

    // Underrun after one of three bytes
    set_timing(2, 3, 4, 5, 6);
    bq = '{8'h11, 8'h22, 8'h33};
    push_burst(2, 3, 4, 5, 6, bq, 1, 1'b1);
    start_req(1'b0);
    drive_bytes(bq, 1, 1'b1);
    drain();
    idle_chk("after_und1");

    // Underrun before any payload: trail follows the sync byte
    set_timing(1, 1, 1, 2, 1);
    bq = {};
    push_burst(1, 1, 1, 2, 1, bq, 0, 1'b1);
    start_req(1'b0);
    drive_bytes(bq, 0, 1'b1);
    drain();
    idle_chk("after_und0");

    // Back-to-back with ths_zero changed mid-burst
    set_timing(2, 3, 4, 5, 6);
    bq = '{8'h01, 8'h82};
    b2 = '{8'h7F};
    push_burst(2, 3, 4, 5, 6, bq, 2, 1'b0);
    l1 = sb_q.size();
    push_burst(2, 3, 9, 5, 6, b2, 1, 1'b0);
    l2 = sb_q.size() - l1;
    start_req(1'b1);
    ths_zero_i = 8'd9;
    bb = 0;
    fork
      begin
        drive_bytes(bq, 2, 1'b0);
        drive_bytes(b2, 1, 1'b0);
      end
      begin
        while (sb_q.size() > l2 - 1 && bb < 500) begin
          @(negedge clk);
          #1;
          bb++;
        end
        @(posedge clk);
        #1;
        req_i = 1'b0;
      end
    join
    drain();
    idle_chk("after_b2b");

    // Disabled lane: LP tri-stated and requests ignored
    enable_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("dis_lp_oe", lp_oe_o, 0);
    req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    chk("dis_no_burst", busy_o, 0);
    enable_i = 1'b1;

    // Asynchronous reset during DATA
    check_en = 1'b0;
    set_timing(2, 3, 4, 5, 6);
    @(negedge clk);
    req_i = 1'b1;
    @(posedge clk);
    #1;
    req_i = 1'b0; valid_i = 1'b1; d_i = 8'h11; last_i = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("pre_rst_soe", serdes_oe_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_soe", serdes_oe_o, 0);
    chk("arst_lp", {lp_oe_o, lp_p_o, lp_n_o}, 3'b011);
    chk("arst_data", serdes_data_o, 8'h00);
    chk("arst_flags", {ready_o, busy_o, underrun_o}, 3'b000);
    valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_en = 1'b1;
    idle_chk("after_arst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
